// File: rtl/pf_port_arbiter_pkg.sv
// Request/response structures shared by the load unit, the prefetcher and the
// dcache read port.
package pf_port_arbiter_pkg;

  // Request towards the dcache: request-phase fields plus tag-phase fields.
  typedef struct packed {
    logic [11:0] address_index;
    logic [19:0] address_tag;
    logic [63:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [7:0]  data_be;
    logic [1:0]  data_size;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_i_t;

  // Response from the dcache.
  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

endpackage

// File: rtl/pf_port_arbiter.sv
// Shares one dcache read port between the load unit (CPU, fixed priority)
// and the prefetcher (PF). Grants are tracked in an in-order owner FIFO so
// responses return to whoever was granted; the cycle after a grant the
// granted requester owns the tag-phase fields.
//
// Handshake: a request is accepted only in a cycle where cache_port_o.data_req
// and cache_port_i.data_gnt are both high; that grant is forwarded to the
// winner alone. Responses (data_rvalid) are consumed unconditionally in the
// cycle they appear; there is no back-pressure on the response path.
module pf_port_arbiter
  import pf_port_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2  // legal 1..4
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  dcache_req_i_t cpu_port_i,
  output dcache_req_o_t cpu_port_o,
  input  dcache_req_i_t pf_port_i,
  output dcache_req_o_t pf_port_o,
  output dcache_req_i_t cache_port_o,
  input  dcache_req_o_t cache_port_i,
  output logic          pf_busy_o,
  output logic [15:0]   preempt_cnt_o,
  output logic          err_o
);

  localparam logic [2:0] DEPTH_C = 3'(Depth);

  // Owner FIFO as a shift register, head at bit 0 (0 = CPU, 1 = PF).
  logic [3:0]  r_ids;
  logic [2:0]  r_count;
  logic        r_tag_vld;
  logic        r_tag_id;
  logic        r_err;
  logic [15:0] r_preempt;

  logic       w_full;
  logic       w_req_any;
  logic       w_win_pf;
  logic       w_gnt;
  logic       w_pop;
  logic       w_err_set;
  logic       w_head_id;
  logic [1:0] w_wr_idx;
  logic [3:0] w_ids_nxt;
  logic [2:0] w_count_nxt;
  logic [3:0] w_valid_mask;

  // Request-phase winner, grant qualification and FIFO bookkeeping.
  always_comb begin
    w_full    = (r_count == DEPTH_C);
    w_req_any = cpu_port_i.data_req | pf_port_i.data_req;
    w_win_pf  = ~cpu_port_i.data_req & pf_port_i.data_req;
    w_gnt     = rst_ni & cache_port_i.data_gnt & w_req_any & ~w_full;
    w_pop     = rst_ni & cache_port_i.data_rvalid & (r_count != 3'd0);
    w_err_set = cache_port_i.data_rvalid & (r_count == 3'd0);
    w_head_id = r_ids[0];
    // A pop shifts the queue down, so a simultaneous push lands one lower.
    w_wr_idx  = w_pop ? 2'(r_count - 3'd1) : 2'(r_count);
    w_ids_nxt = w_pop ? {1'b0, r_ids[3:1]} : r_ids;
    if (w_gnt) begin
      w_ids_nxt[w_wr_idx] = w_win_pf;
    end
    w_count_nxt = r_count;
    if (w_gnt && !w_pop) begin
      w_count_nxt = r_count + 3'd1;
    end else if (!w_gnt && w_pop) begin
      w_count_nxt = r_count - 3'd1;
    end
  end

  // Mask of occupied FIFO slots, used to ignore stale entries above the count.
  always_comb begin
    w_valid_mask = 4'b0000;
    case (r_count)
      3'd1:    w_valid_mask = 4'b0001;
      3'd2:    w_valid_mask = 4'b0011;
      3'd3:    w_valid_mask = 4'b0111;
      3'd4:    w_valid_mask = 4'b1111;
      default: w_valid_mask = 4'b0000;
    endcase
  end

  // Owner FIFO and tag-phase owner registers.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ids     <= 4'b0000;
      r_count   <= 3'd0;
      r_tag_vld <= 1'b0;
      r_tag_id  <= 1'b0;
    end else begin
      r_ids     <= w_ids_nxt;
      r_count   <= w_count_nxt;
      r_tag_vld <= w_gnt;
      r_tag_id  <= w_win_pf;
    end
  end

  // Sticky error flag and saturating count of cycles the prefetcher lost.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err     <= 1'b0;
      r_preempt <= 16'h0000;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (cpu_port_i.data_req && pf_port_i.data_req && !w_full &&
          (r_preempt != 16'hFFFF)) begin
        r_preempt <= r_preempt + 16'h0001;
      end
    end
  end

  // Port muxing: request fields from the winner, tag fields from the tag owner,
  // responses to the FIFO head owner.
  always_comb begin
    cache_port_o = '0;
    cpu_port_o   = '0;
    pf_port_o    = '0;
    if (rst_ni) begin
      if (cpu_port_i.data_req) begin
        cache_port_o.address_index = cpu_port_i.address_index;
        cache_port_o.data_wdata    = cpu_port_i.data_wdata;
        cache_port_o.data_we       = cpu_port_i.data_we;
        cache_port_o.data_be       = cpu_port_i.data_be;
        cache_port_o.data_size     = cpu_port_i.data_size;
      end else if (pf_port_i.data_req) begin
        cache_port_o.address_index = pf_port_i.address_index;
        cache_port_o.data_wdata    = pf_port_i.data_wdata;
        cache_port_o.data_we       = pf_port_i.data_we;
        cache_port_o.data_be       = pf_port_i.data_be;
        cache_port_o.data_size     = pf_port_i.data_size;
      end
      cache_port_o.data_req = w_req_any & ~w_full;
      if (r_tag_vld) begin
        if (r_tag_id) begin
          cache_port_o.address_tag = pf_port_i.address_tag;
          cache_port_o.tag_valid   = pf_port_i.tag_valid;
          cache_port_o.kill_req    = pf_port_i.kill_req;
        end else begin
          cache_port_o.address_tag = cpu_port_i.address_tag;
          cache_port_o.tag_valid   = cpu_port_i.tag_valid;
          cache_port_o.kill_req    = cpu_port_i.kill_req;
        end
      end
      cpu_port_o.data_gnt = w_gnt & ~w_win_pf;
      pf_port_o.data_gnt  = w_gnt & w_win_pf;
      if (w_pop) begin
        if (w_head_id) begin
          pf_port_o.data_rvalid  = 1'b1;
          pf_port_o.data_rdata   = cache_port_i.data_rdata;
        end else begin
          cpu_port_o.data_rvalid = 1'b1;
          cpu_port_o.data_rdata  = cache_port_i.data_rdata;
        end
      end
    end
  end

  assign pf_busy_o     = (|(r_ids & w_valid_mask)) | (r_tag_vld & r_tag_id);
  assign preempt_cnt_o = r_preempt;
  assign err_o         = r_err;

endmodule
